jtdsp16_dram: RTL and testbench
===============================

Name: jtdsp16_dram

Overview:
- Internal data RAM stage of the DSP16 core, directly downstream of the RAM address arithmetic unit.
- Consumes the read and write addresses the AAU produces from r0–r3/pointer post-modification, plus the write data from the data path.
- Returns registered read data to the data arithmetic unit.
- Backed by a single-port array with a one-entry posted-write buffer, read forwarding and a stall output for port conflicts.

Parameters:
- AW, 11: array address width (2^AW words; 2048 for DSP16A). Upper address bits are ignored.
- DW, 16: data word width.

Ports:
- rst  input  1  asynchronous reset, active-high
- clk  input  1  clock
- cen  input  1  clock enable; all state advances only when cen=1
- rd_en  input  1  read request this instruction cycle
- rd_addr  input  16  read address from AAU
- wr_en  input  1  write request this instruction cycle
- wr_addr  input  16  write address from AAU
- din  input  DW  write data
- dout  output  DW  read data, registered
- dout_valid  output  1  dout updated by the read accepted on the previous cen cycle
- hold  output  1  combinational stall: requests not accepted this cycle
- buf_busy  output  1  posted-write buffer occupied (debug/verification)

Behaviour:
- Reset (async, any time, including mid-stall):
  - dout=0, dout_valid=0, buffer valid flag=0, buffer addr/data=0.
  - Array contents are not cleared (undefined). A write pending in the buffer at reset is lost.
- Address use: only bits [AW-1:0] of rd_addr/wr_addr are used; aliasing is intended.
- hold = buf_v & wr_en & rd_en. hold ignores cen in value, but has effect only on cen cycles.
- Per cen=1 cycle, in priority order:
  1. hold=1:
     - Array commits the buffer entry.
     - Buffer is cleared.
     - Read and write are not accepted.
     - dout unchanged; dout_valid=0.
     - Upstream holds rd/wr signals and presents them again.
  2. rd_en=1, not held:
     - Array read at rd_addr.
     - If buf_v and buffer addr == rd_addr[AW-1:0], dout=buffer data (forwarding); otherwise dout=array data.
     - dout_valid=1 on the next edge, so latency is one cen cycle.
     - Buffer is not committed this cycle.
  3. rd_en=0 and buf_v=1: array commits the buffer entry.
- Write capture, any cen cycle not held:
  - If wr_en=1, buffer gets {wr_addr[AW-1:0], din} and buf_v=1.
  - If the buffer was committed in the same cycle (case 3), the new entry replaces it; no data is lost.
  - wr_en with buf_v=1 and rd_en=0 is therefore legal with no stall.
- Same-cycle read and write to the same address: the read returns the value before this write, i.e. the forwarded older buffer entry if it matches, otherwise the array value. Read-before-write ordering within an instruction.
- dout_valid deasserts on any cen cycle without an accepted read. dout holds its last value.
- cen=0: no state changes; dout, dout_valid and buf_busy hold; hold still reflects its inputs.
- Back-to-back writes with no reads: buffer drains one entry per cen cycle. Sustainable indefinitely.
- buf_busy = buf_v.

Test Plan:
- Reset, then write 0x1234 to 0x0005, then idle two cycles, then read 0x0005 → dout=0x1234, dout_valid=1 one cen cycle after the read; buf_busy=0 before the read.
- Write 0xBEEF to 0x0010, then read 0x0010 on the very next cycle → forwarded dout=0xBEEF, buf_busy=1 during the read.
- With 0x0001 held in the buffer at 0x0020, assert rd_en (0x0030) and wr_en (0x0040, 0x5555) together:
  - hold=1 for one cen cycle, dout_valid=0.
  - The next cycle is accepted.
  - Later reads: 0x0020=0x0001, 0x0040=0x5555.
- Same-cycle read and write to 0x0007, where the old value 0x0AAA is in the array and the new value is 0x0BBB → dout=0x0AAA; a subsequent read of 0x0007 returns 0x0BBB.
- Aliasing: write 0x7777 to 0x0803 (AW=11), then read 0x0003 → 0x7777.
- Toggle cen low for 3 clocks mid-sequence with a pending write and a pending read → outputs frozen, results identical to the cen-high run. Assert rst with buf_busy=1 → buf_busy=0, dout=0, dout_valid=0 immediately.

Source files
------------

// File: rtl/jtdsp16_dram_if.sv
// jtdsp16_dram_if: request/response bundle between the AAU/data path and the
// internal data RAM.
//
// Handshake: a request is presented on rd_en/wr_en with its address and data.
// It is accepted on a clock edge where cen=1 and hold=0. While hold=1 the
// upstream keeps every request signal stable and presents it again on the
// next cycle. hold acts as the inverted ready. There is no separate valid:
// rd_en and wr_en are the valids.
//
// Signals:
//   cen        clock enable
//   rd_en      read request
//   rd_addr    read address, 16 bits
//   wr_en      write request
//   wr_addr    write address, 16 bits
//   din        write data
//   dout       registered read data
//   dout_valid dout refreshed by the read accepted on the previous cen cycle
//   hold       combinational stall
//   buf_busy   posted-write buffer occupied
interface jtdsp16_dram_if #(
   parameter int DW = 16
);
   logic          cen;
   logic          rd_en;
   logic [15:0]   rd_addr;
   logic          wr_en;
   logic [15:0]   wr_addr;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          hold;
   logic          buf_busy;

   modport master (
      output cen, rd_en, rd_addr, wr_en, wr_addr, din,
      input  dout, dout_valid, hold, buf_busy
   );

   modport slave (
      input  cen, rd_en, rd_addr, wr_en, wr_addr, din,
      output dout, dout_valid, hold, buf_busy
   );
endinterface

// File: rtl/jtdsp16_dram.sv
// jtdsp16_dram: internal data RAM of the DSP16 core.
//
// The RAM is a single-port array with a one-entry posted-write buffer. A write
// lands in the buffer first. The buffer drains into the array on any enabled
// cycle where the port is not needed for a read. A read that hits the buffer
// address is forwarded from the buffer. When a read, a write and a full buffer
// all meet in one cycle, the core stalls (hold) for one cycle and the buffer
// drains.
//
// Ports:
//   clk  clock
//   rst  asynchronous reset, active-high
//   bus  jtdsp16_dram_if.slave carrying the following signals:
//        cen, rd_en, rd_addr, wr_en, wr_addr, din,
//        dout, dout_valid, hold, buf_busy
module jtdsp16_dram #(
   parameter int AW = 11,
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            rst,
   jtdsp16_dram_if.slave   bus
);
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [0:DEPTH-1];

   logic          buf_v;
   logic [AW-1:0] buf_a;
   logic [DW-1:0] buf_d;
   logic [DW-1:0] dout_r;
   logic          dout_valid_r;

   logic [AW-1:0] rd_a;
   logic [AW-1:0] wr_a;
   logic          hold;
   logic          commit;
   logic          fwd;

   // Upper address bits are dropped, so addresses alias on purpose.
   assign rd_a = bus.rd_addr[AW-1:0];
   assign wr_a = bus.wr_addr[AW-1:0];

   assign hold = buf_v & bus.wr_en & bus.rd_en;

   // The port belongs to the buffer whenever the cycle carries no accepted read.
   assign commit = bus.cen & buf_v & (hold | ~bus.rd_en);

   // Forwarding uses the entry as it was before this cycle's write capture.
   // This gives read-before-write ordering for a same-cycle read and write.
   assign fwd = buf_v & (buf_a == rd_a);

   // The array holds no reset, so its contents survive rst.
   always_ff @(posedge clk) begin
      if (commit) mem[buf_a] <= buf_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_r       <= '0;
         dout_valid_r <= 1'b0;
         buf_v        <= 1'b0;
         buf_a        <= '0;
         buf_d        <= '0;
      end else if (bus.cen) begin
         if (hold) begin
            // The buffer drains. Both requests are retried next cycle.
            dout_valid_r <= 1'b0;
            buf_v        <= 1'b0;
         end else begin
            if (bus.rd_en) begin
               dout_r       <= fwd ? buf_d : mem[rd_a];
               dout_valid_r <= 1'b1;
            end else begin
               dout_valid_r <= 1'b0;
            end
            if (bus.wr_en) begin
               // This may replace an entry that is committed on this same edge.
               buf_v <= 1'b1;
               buf_a <= wr_a;
               buf_d <= bus.din;
            end else if (!bus.rd_en) begin
               buf_v <= 1'b0;
            end
         end
      end
   end

   assign bus.dout       = dout_r;
   assign bus.dout_valid = dout_valid_r;
   assign bus.hold       = hold;
   assign bus.buf_busy   = buf_v;
endmodule

// File: tb/tb_jtdsp16_dram.sv
// tb_jtdsp16_dram: directed self-checking bench for jtdsp16_dram.
//
// Inputs are driven 1 ns after a rising edge. Registered outputs are sampled
// 1 ns after the following rising edge. The combinational hold is sampled
// after the inputs settle.
module tb_jtdsp16_dram;
   logic clk;
   logic rst;

   int n_chk  = 0;
   int n_pass = 0;

   jtdsp16_dram_if #(.DW(16)) bus ();

   jtdsp16_dram #(.AW(11), .DW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard check
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // driver tasks
   task automatic drive(input logic rd, input logic [15:0] ra,
                        input logic wr, input logic [15:0] wa, input logic [15:0] d);
      bus.rd_en   = rd;
      bus.rd_addr = ra;
      bus.wr_en   = wr;
      bus.wr_addr = wa;
      bus.din     = d;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      drive(1'b0, 16'h0, 1'b1, a, d);
      cyc();
   endtask

   task automatic rd(input logic [15:0] a);
      drive(1'b1, a, 1'b0, 16'h0, 16'h0);
      cyc();
   endtask

   initial begin
      rst = 1'b1;
      bus.cen = 1'b1;
      idle();
      #11;
      chk("rst_dout", bus.dout, 16'h0);
      chk("rst_valid", {15'h0, bus.dout_valid}, 16'h0);
      chk("rst_busy", {15'h0, bus.buf_busy}, 16'h0);
      chk("rst_hold", {15'h0, bus.hold}, 16'h0);
      rst = 1'b0;
      cyc();

      // Write, drain, then read back from the array.
      wr(16'h0005, 16'h1234);
      chk("t1_busy_after_wr", {15'h0, bus.buf_busy}, 16'h1);
      idle(); cyc();
      idle(); cyc();
      chk("t1_busy_before_rd", {15'h0, bus.buf_busy}, 16'h0);
      rd(16'h0005);
      chk("t1_dout", bus.dout, 16'h1234);
      chk("t1_valid", {15'h0, bus.dout_valid}, 16'h1);
      idle(); cyc();
      chk("t1_valid_drop", {15'h0, bus.dout_valid}, 16'h0);
      chk("t1_dout_hold", bus.dout, 16'h1234);

      // Read on the cycle after the write is forwarded from the buffer.
      wr(16'h0010, 16'hBEEF);
      drive(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
      chk("t2_busy_during_rd", {15'h0, bus.buf_busy}, 16'h1);
      cyc();
      chk("t2_fwd_dout", bus.dout, 16'hBEEF);
      chk("t2_fwd_valid", {15'h0, bus.dout_valid}, 16'h1);
      chk("t2_busy_kept", {15'h0, bus.buf_busy}, 16'h1);
      idle(); cyc();
      chk("t2_drained", {15'h0, bus.buf_busy}, 16'h0);

      // A read, a write and a full buffer in one cycle stall the core.
      wr(16'h0030, 16'h3333);
      wr(16'h0020, 16'h0001);
      drive(1'b1, 16'h0030, 1'b1, 16'h0040, 16'h5555);
      chk("t3_hold", {15'h0, bus.hold}, 16'h1);
      cyc();
      chk("t3_hold_valid", {15'h0, bus.dout_valid}, 16'h0);
      chk("t3_hold_dout", bus.dout, 16'hBEEF);
      chk("t3_hold_busy", {15'h0, bus.buf_busy}, 16'h0);
      chk("t3_hold_released", {15'h0, bus.hold}, 16'h0);
      cyc();
      chk("t3_acc_dout", bus.dout, 16'h3333);
      chk("t3_acc_valid", {15'h0, bus.dout_valid}, 16'h1);
      chk("t3_acc_busy", {15'h0, bus.buf_busy}, 16'h1);
      idle(); cyc();
      rd(16'h0020);
      chk("t3_rd20", bus.dout, 16'h0001);
      rd(16'h0040);
      chk("t3_rd40", bus.dout, 16'h5555);

      // Same-cycle read and write to one address read the old value.
      wr(16'h0007, 16'h0AAA);
      idle(); cyc();
      drive(1'b1, 16'h0007, 1'b1, 16'h0007, 16'h0BBB);
      chk("t4_no_hold", {15'h0, bus.hold}, 16'h0);
      cyc();
      chk("t4_old", bus.dout, 16'h0AAA);
      rd(16'h0007);
      chk("t4_new_fwd", bus.dout, 16'h0BBB);
      idle(); cyc();
      rd(16'h0007);
      chk("t4_new_array", bus.dout, 16'h0BBB);

      // Upper address bits alias.
      wr(16'h0803, 16'h7777);
      idle(); cyc();
      rd(16'h0003);
      chk("t5_alias", bus.dout, 16'h7777);

      // With cen low, the outputs freeze and hold still follows the inputs.
      wr(16'h0050, 16'h6006);
      chk("t6_busy", {15'h0, bus.buf_busy}, 16'h1);
      bus.cen = 1'b0;
      drive(1'b1, 16'h0050, 1'b1, 16'h0051, 16'h1111);
      chk("t6_hold_cen0", {15'h0, bus.hold}, 16'h1);
      drive(1'b1, 16'h0050, 1'b0, 16'h0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t6_frz_dout", bus.dout, 16'h7777);
         chk("t6_frz_valid", {15'h0, bus.dout_valid}, 16'h0);
         chk("t6_frz_busy", {15'h0, bus.buf_busy}, 16'h1);
      end
      bus.cen = 1'b1;
      cyc();
      chk("t6_dout", bus.dout, 16'h6006);
      chk("t6_valid", {15'h0, bus.dout_valid}, 16'h1);

      // Asynchronous reset with a write pending clears the outputs immediately.
      idle(); cyc();
      drive(1'b1, 16'h0050, 1'b1, 16'h0060, 16'h1111);
      cyc();
      chk("t7_pre_busy", {15'h0, bus.buf_busy}, 16'h1);
      chk("t7_pre_valid", {15'h0, bus.dout_valid}, 16'h1);
      idle();
      #2;
      rst = 1'b1;
      #1;
      chk("t7_rst_busy", {15'h0, bus.buf_busy}, 16'h0);
      chk("t7_rst_dout", bus.dout, 16'h0);
      chk("t7_rst_valid", {15'h0, bus.dout_valid}, 16'h0);
      rst = 1'b0;
      cyc();

      // final report
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
